// File: rtl/strip_place_pkg.sv
// rtl/strip_place_pkg.sv - shared constants, S1->S2 payload and strike decision
package strip_place_pkg;

  localparam int NUM_STRIPS_D = 4;
  localparam int ID_W_D       = 4;
  localparam int OCC_W_D      = 8;
  localparam int WIN_W_D      = 5;
  localparam int STRIP_CAP_D  = 200;
  localparam int CNT_W_D      = 4;

  // Payload fields are sized for the widest supported instance; narrower ones zero-extend
  localparam int PL_ID_W  = 16;
  localparam int PL_OCC_W = 16;

  typedef struct packed {
    logic [PL_ID_W-1:0]  id;
    logic [PL_OCC_W-1:0] width;
    logic                no_strip;
    logic [PL_OCC_W-1:0] width_in;
  } s1_payload_t;

  function automatic logic strike_of(input s1_payload_t p, input int cap);
    logic [PL_OCC_W:0] sum;
    sum = {1'b0, p.width} + {1'b0, p.width_in};
    return p.no_strip || (int'(sum) > cap);
  endfunction

endpackage

// File: rtl/strip_min_tree.sv
// rtl/strip_min_tree.sv - combinational least-occupied enabled strip selector
// Strict less-than keeps the earliest slot on ties.
module strip_min_tree #(
  parameter int NUM_STRIPS = 4,
  parameter int ID_W       = 4,
  parameter int OCC_W      = 8
) (
  input  logic [NUM_STRIPS*ID_W-1:0]  i_strip_id,
  input  logic [NUM_STRIPS*OCC_W-1:0] i_occupied_width,
  input  logic [NUM_STRIPS-1:0]       i_strip_en,
  output logic [ID_W-1:0]             o_id,
  output logic [OCC_W-1:0]            o_width,
  output logic                        o_no_strip
);

  logic             w_found;
  logic [ID_W-1:0]  w_id;
  logic [OCC_W-1:0] w_w;

  always_comb begin
    w_found = 1'b0;
    w_id    = '0;
    w_w     = '0;
    for (int i = 0; i < NUM_STRIPS; i++) begin
      if (i_strip_en[i] && (!w_found || (i_occupied_width[i*OCC_W +: OCC_W] < w_w))) begin
        w_found = 1'b1;
        w_id    = i_strip_id[i*ID_W +: ID_W];
        w_w     = i_occupied_width[i*OCC_W +: OCC_W];
      end
    end
  end

  assign o_id       = w_id;
  assign o_width    = w_w;
  assign o_no_strip = ~w_found;

endmodule

// File: rtl/strip_place_pipe.sv
// rtl/strip_place_pipe.sv - two-stage strip placement with handshake and strike counter
// S1 registers the min-tree pick, S2 registers the placement result.
module strip_place_pipe #(
  parameter int NUM_STRIPS = strip_place_pkg::NUM_STRIPS_D,
  parameter int ID_W       = strip_place_pkg::ID_W_D,
  parameter int OCC_W      = strip_place_pkg::OCC_W_D,
  parameter int WIN_W      = strip_place_pkg::WIN_W_D,
  parameter int STRIP_CAP  = strip_place_pkg::STRIP_CAP_D,
  parameter int CNT_W      = strip_place_pkg::CNT_W_D
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  input  logic [NUM_STRIPS*ID_W-1:0]  i_strip_id,
  input  logic [NUM_STRIPS*OCC_W-1:0] i_occupied_width,
  input  logic [NUM_STRIPS-1:0]       i_strip_en,
  input  logic [WIN_W-1:0]            i_width_in,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [ID_W-1:0]             o_min_occupied_strip_id,
  output logic [OCC_W-1:0]            o_min_occupied_strip_width,
  output logic [OCC_W-1:0]            o_new_occupied_strip_width,
  output logic                        o_strike_flag,
  output logic                        o_no_strip,
  input  logic                        i_strike_clr,
  output logic [CNT_W-1:0]            o_strike_count
);
  import strip_place_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             w_s1_adv, w_s2_adv;
  logic [ID_W-1:0]  w_min_id;
  logic [OCC_W-1:0] w_min_w;
  logic             w_no_strip;
  s1_payload_t      w_s1_next;
  logic [OCC_W:0]   w_sum;
  logic             w_strike;

  logic             r_s1_valid;
  s1_payload_t      r_s1;
  logic             r_s2_valid;
  logic [ID_W-1:0]  r_id;
  logic [OCC_W-1:0] r_min_w;
  logic [OCC_W-1:0] r_new_w;
  logic             r_strike;
  logic             r_no_strip;
  logic [CNT_W-1:0] r_cnt;

  strip_min_tree #(
    .NUM_STRIPS(NUM_STRIPS),
    .ID_W      (ID_W),
    .OCC_W     (OCC_W)
  ) u_min_tree (
    .i_strip_id      (i_strip_id),
    .i_occupied_width(i_occupied_width),
    .i_strip_en      (i_strip_en),
    .o_id            (w_min_id),
    .o_width         (w_min_w),
    .o_no_strip      (w_no_strip)
  );

  assign w_s2_adv   = !r_s2_valid || i_out_ready;
  assign w_s1_adv   = !r_s1_valid || w_s2_adv;
  assign o_in_ready = w_s1_adv;

  always_comb begin
    w_s1_next          = '0;
    w_s1_next.id       = PL_ID_W'(w_min_id);
    w_s1_next.width    = PL_OCC_W'(w_min_w);
    w_s1_next.no_strip = w_no_strip;
    w_s1_next.width_in = PL_OCC_W'(i_width_in);
  end

  // Full-width sum so a near-full strip plus width_in cannot wrap past the cap check
  assign w_sum    = {1'b0, r_s1.width[OCC_W-1:0]} + (OCC_W+1)'(r_s1.width_in[WIN_W-1:0]);
  assign w_strike = strike_of(r_s1, STRIP_CAP);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
    end else if (w_s1_adv) begin
      r_s1_valid <= i_in_valid;
      if (i_in_valid) r_s1 <= w_s1_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s2_valid <= 1'b0;
      r_id       <= '0;
      r_min_w    <= '0;
      r_new_w    <= '0;
      r_strike   <= 1'b0;
      r_no_strip <= 1'b0;
    end else if (w_s2_adv) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_id       <= r_s1.id[ID_W-1:0];
        r_min_w    <= r_s1.width[OCC_W-1:0];
        r_new_w    <= w_strike ? r_s1.width[OCC_W-1:0] : w_sum[OCC_W-1:0];
        r_strike   <= w_strike;
        r_no_strip <= r_s1.no_strip;
      end
    end
  end

  // Clear has priority: a strike handshaking in the same cycle is dropped
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_strike_clr) begin
      r_cnt <= '0;
    end else if (r_s2_valid && i_out_ready && r_strike && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_out_valid                = r_s2_valid;
  assign o_min_occupied_strip_id    = r_id;
  assign o_min_occupied_strip_width = r_min_w;
  assign o_new_occupied_strip_width = r_new_w;
  assign o_strike_flag              = r_strike;
  assign o_no_strip                 = r_no_strip;
  assign o_strike_count             = r_cnt;

endmodule

// File: tb/tb_strip_place_pipe.sv
// tb/tb_strip_place_pipe.sv - randomized scoreboard bench for strip_place_pipe
module tb_strip_place_pipe;

  localparam int N   = 4;
  localparam int IDW = 4;
  localparam int OW  = 8;
  localparam int WW  = 5;
  localparam int CAP = 200;
  localparam int CW  = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            i_in_valid;
  logic            o_in_ready;
  logic [N*IDW-1:0] i_strip_id;
  logic [N*OW-1:0]  i_occupied_width;
  logic [N-1:0]     i_strip_en;
  logic [WW-1:0]    i_width_in;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [IDW-1:0]  o_id;
  logic [OW-1:0]   o_minw;
  logic [OW-1:0]   o_neww;
  logic            o_strike;
  logic            o_nos;
  logic            i_strike_clr;
  logic [CW-1:0]   o_cnt;

  always #5 clk = ~clk;

  strip_place_pipe dut (
    .i_clk                     (clk),
    .i_rst_n                   (rst_n),
    .i_in_valid                (i_in_valid),
    .o_in_ready                (o_in_ready),
    .i_strip_id                (i_strip_id),
    .i_occupied_width          (i_occupied_width),
    .i_strip_en                (i_strip_en),
    .i_width_in                (i_width_in),
    .o_out_valid               (o_out_valid),
    .i_out_ready               (i_out_ready),
    .o_min_occupied_strip_id   (o_id),
    .o_min_occupied_strip_width(o_minw),
    .o_new_occupied_strip_width(o_neww),
    .o_strike_flag             (o_strike),
    .o_no_strip                (o_nos),
    .i_strike_clr              (i_strike_clr),
    .o_strike_count            (o_cnt)
  );

  typedef struct {
    int id;
    int minw;
    int neww;
    bit strike;
    bit nos;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exp_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  // Reference: lowest eligible width, first slot holding it, then the capacity rule
  function automatic exp_t model(input logic [N*IDW-1:0] ids, input logic [N*OW-1:0] ws,
                                 input logic [N-1:0] en, input logic [WW-1:0] win);
    exp_t e;
    int mn, sum, pick;
    e = '{id: 0, minw: 0, neww: 0, strike: 1'b1, nos: 1'b1};
    if (en == '0) return e;
    mn = 1 << 30;
    for (int i = 0; i < N; i++)
      if (en[i]) mn = (int'(ws[i*OW +: OW]) < mn) ? int'(ws[i*OW +: OW]) : mn;
    pick = -1;
    for (int i = N - 1; i >= 0; i--)
      if (en[i] && int'(ws[i*OW +: OW]) == mn) pick = i;
    sum      = mn + int'(win);
    e.id     = int'(ids[pick*IDW +: IDW]);
    e.minw   = mn;
    e.nos    = 1'b0;
    e.strike = (sum > CAP);
    e.neww   = e.strike ? mn : sum;
    return e;
  endfunction

  bit              prev_stall = 1'b0;
  logic [IDW-1:0]  h_id;
  logic [OW-1:0]   h_minw, h_neww;
  logic            h_strike, h_nos;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      check("strike_count", o_cnt, exp_cnt);
      if (prev_stall) begin
        check("hold_valid", o_out_valid, 1);
        check("hold_id", o_id, h_id);
        check("hold_minw", o_minw, h_minw);
        check("hold_neww", o_neww, h_neww);
        check("hold_strike", o_strike, h_strike);
        check("hold_nos", o_nos, h_nos);
      end
      if (o_out_valid && i_out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_output: got out_valid=1 expected none pending");
        end else begin
          e = q.pop_front();
          check("sb_id", o_id, e.id);
          check("sb_minw", o_minw, e.minw);
          check("sb_neww", o_neww, e.neww);
          check("sb_strike", o_strike, e.strike);
          check("sb_no_strip", o_nos, e.nos);
          if (!i_strike_clr && e.strike && exp_cnt < CMAX) exp_cnt++;
        end
      end
      if (i_strike_clr) exp_cnt = 0;
      if (i_in_valid && o_in_ready)
        q.push_back(model(i_strip_id, i_occupied_width, i_strip_en, i_width_in));
      prev_stall = o_out_valid && !i_out_ready;
      h_id = o_id; h_minw = o_minw; h_neww = o_neww; h_strike = o_strike; h_nos = o_nos;
    end
  end

  task automatic set_req(input int w0, input int w1, input int w2, input int w3,
                         input logic [3:0] en, input int win);
    i_strip_id       = {4'd8, 4'd7, 4'd6, 4'd5};
    i_occupied_width = {8'(w3), 8'(w2), 8'(w1), 8'(w0)};
    i_strip_en       = en;
    i_width_in       = 5'(win);
  endtask

  // One request into an empty pipe with out_ready=1; checks latency and literal results
  task automatic send_one(input string tag, input int eid, input int eminw, input int eneww,
                          input int estrike, input int enos);
    int lat;
    bit got;
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    lat = 1;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (o_out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, got ? lat : 32'hFFFF_FFFF, 2);
    if (got) begin
      check({tag, "_id"}, o_id, eid);
      check({tag, "_minw"}, o_minw, eminw);
      check({tag, "_neww"}, o_neww, eneww);
      check({tag, "_strike"}, o_strike, estrike);
      check({tag, "_no_strip"}, o_nos, enos);
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_out(input string tag);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (o_out_valid) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check({tag, "_seen"}, got, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int acc, cyc;
    rst_n = 1'b0;
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    i_strike_clr = 1'b0;
    set_req(0, 0, 0, 0, 4'b1111, 0);
    #1;
    check("reset_in_ready", o_in_ready, 1);
    check("reset_out_valid", o_out_valid, 0);
    check("reset_count", o_cnt, 0);
    check("reset_neww", o_neww, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // pinned literal cases
    set_req(40, 12, 12, 90, 4'b1111, 20);
    send_one("tie", 6, 12, 32, 0, 0);
    set_req(50, 5, 60, 70, 4'b1101, 10);
    send_one("masked", 5, 50, 60, 0, 0);
    set_req(50, 5, 60, 70, 4'b0000, 10);
    send_one("none_en", 0, 0, 0, 1, 1);
    check("count_after_none", o_cnt, 1);
    set_req(195, 230, 250, 255, 4'b1111, 5);
    send_one("at_cap", 5, 195, 200, 0, 0);
    set_req(195, 230, 250, 255, 4'b1111, 6);
    send_one("over_cap", 5, 195, 195, 1, 0);
    set_req(255, 255, 255, 255, 4'b1111, 31);
    send_one("wrap", 5, 255, 255, 1, 0);
    check("count_after_wrap", o_cnt, 3);

    i_strike_clr = 1'b1;
    @(posedge clk); #1;
    i_strike_clr = 1'b0;
    check("count_cleared", o_cnt, 0);

    // saturation
    set_req(1, 2, 3, 4, 4'b0000, 0);
    i_in_valid = 1'b1;
    repeat (20) @(posedge clk);
    #1 i_in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("count_saturated", o_cnt, CMAX);

    // clear coinciding with a strike handshake, twice
    for (int r = 0; r < 2; r++) begin
      i_in_valid = 1'b1;
      @(posedge clk); #1;
      i_in_valid = 1'b0;
      wait_out("clr_coincide");
      i_strike_clr = 1'b1;
      @(posedge clk); #1;
      i_strike_clr = 1'b0;
      check("count_clr_wins", o_cnt, 0);
      if (r == 0) send_one("one_strike", 0, 0, 0, 1, 1);
      if (r == 0) check("count_one", o_cnt, 1);
    end

    // randomized traffic with backpressure
    acc = 0;
    cyc = 0;
    while (acc < 1000 && cyc < 20000) begin
      i_in_valid = ($urandom_range(0, 3) != 0);
      i_strip_id = 16'($urandom);
      for (int s = 0; s < N; s++)
        i_occupied_width[s*OW +: OW] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(170, 210))
                                                                   : 8'($urandom_range(0, 255));
      i_strip_en   = 4'($urandom);
      i_width_in   = 5'($urandom);
      i_out_ready  = ($urandom_range(0, 3) != 0);
      i_strike_clr = ($urandom_range(0, 31) == 0);
      #1;
      if (i_in_valid && o_in_ready) acc++;
      @(posedge clk); #1;
      cyc++;
    end
    check("random_accepted", acc, 1000);
    i_in_valid = 1'b0;
    i_out_ready = 1'b1;
    i_strike_clr = 1'b0;
    for (int k = 0; k < 20 && q.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain_empty", q.size(), 0);

    // reset with both stages full
    set_req(50, 5, 60, 70, 4'b0000, 1);
    send_one("pre_rst", 0, 0, 0, 1, 1);
    i_out_ready = 1'b0;
    set_req(40, 12, 12, 90, 4'b1111, 20);
    i_in_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_in_valid = 1'b0;
    check("full_in_ready", o_in_ready, 0);
    check("full_out_valid", o_out_valid, 1);
    #1;
    rst_n = 1'b0;
    q.delete();
    exp_cnt = 0;
    #1;
    check("midrst_out_valid", o_out_valid, 0);
    check("midrst_count", o_cnt, 0);
    check("midrst_in_ready", o_in_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    i_out_ready = 1'b1;
    @(posedge clk); #1;
    send_one("post_rst", 6, 12, 32, 0, 0);
    check("post_rst_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
